// File: rtl/reflet_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : reflet_irq_controller
// Description : Memory-mapped external interrupt controller. Latches edge or
//               level events from nb_src peripheral lines, masks them, and
//               routes each onto one of four CPU interrupt_request lines.
//               Registers: PEND, ENA, MODE, ROUTE, CLAIM at base_addr+0..4.
//               Optional macro REFLET_IRQ_CTRL_SYNC_EN inserts a 2-flop
//               synchronizer on every irq_src line.
// Revision    : 1.0 - initial release
// ============================================================================
module reflet_irq_controller #(
  parameter int                  wordsize  = 16,
  parameter int                  nb_src    = 8,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [nb_src-1:0]   irq_src,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  input  logic                read_en,
  output logic [wordsize-1:0] data_out,
  output logic [3:0]          interrupt_request
);

  localparam logic [2:0] c_OFF_PEND  = 3'd0;
  localparam logic [2:0] c_OFF_ENA   = 3'd1;
  localparam logic [2:0] c_OFF_MODE  = 3'd2;
  localparam logic [2:0] c_OFF_ROUTE = 3'd3;
  localparam logic [2:0] c_OFF_CLAIM = 3'd4;

  logic [nb_src-1:0]   w_src;
  logic [nb_src-1:0]   w_edge;
  logic [nb_src-1:0]   w_cand;
  logic [nb_src-1:0]   w_claim_oh;
  logic [wordsize-1:0] w_claim_val;
  logic [wordsize-1:0] w_off;
  logic                w_hit;
  logic                w_wr_pend, w_wr_ena, w_wr_mode, w_wr_route;
  logic                w_rd_claim;

  logic [nb_src-1:0]   prev_q;
  logic [nb_src-1:0]   pend_q,  pend_d;
  logic [nb_src-1:0]   ena_q,   ena_d;
  logic [nb_src-1:0]   mode_q,  mode_d;
  logic [2*nb_src-1:0] route_q, route_d;
  logic [wordsize-1:0] dout_q,  dout_d;
  logic [3:0]          irq_q,   irq_d;

`ifdef REFLET_IRQ_CTRL_SYNC_EN
  logic [nb_src-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer bringing the asynchronous source lines into clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (enable) begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign w_src = sync2_q;
`else
  assign w_src = irq_src;
`endif

  // Window decode: offset is only meaningful when addr lies inside base..base+4
  assign w_off      = addr - base_addr;
  assign w_hit      = (addr >= base_addr) && (w_off <= wordsize'(4));
  assign w_wr_pend  = write_en && w_hit && (w_off[2:0] == c_OFF_PEND);
  assign w_wr_ena   = write_en && w_hit && (w_off[2:0] == c_OFF_ENA);
  assign w_wr_mode  = write_en && w_hit && (w_off[2:0] == c_OFF_MODE);
  assign w_wr_route = write_en && w_hit && (w_off[2:0] == c_OFF_ROUTE);
  assign w_rd_claim = read_en  && w_hit && (w_off[2:0] == c_OFF_CLAIM);

  assign w_edge = w_src & ~prev_q;
  assign w_cand = pend_q & ena_q;

  // Claim priority encoder: lowest-index pending-and-enabled source wins
  always_comb begin
    w_claim_oh  = '0;
    w_claim_val = '0;
    for (int k = nb_src - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        w_claim_oh    = '0;
        w_claim_oh[k] = 1'b1;
        w_claim_val   = wordsize'(k + 1);
      end
    end
  end

  // Next-state for pending and config registers; edge set overrides clears
  always_comb begin
    pend_d = pend_q;
    if (w_wr_pend) begin
      pend_d = pend_d & ~data_in[nb_src-1:0];
    end
    if (w_rd_claim) begin
      pend_d = pend_d & ~w_claim_oh;
    end
    // Level-mode bits simply follow the source, so clears never stick there
    pend_d  = ((pend_d | w_edge) & mode_q) | (w_src & ~mode_q);
    ena_d   = w_wr_ena   ? data_in[nb_src-1:0]   : ena_q;
    mode_d  = w_wr_mode  ? data_in[nb_src-1:0]   : mode_q;
    route_d = w_wr_route ? data_in[2*nb_src-1:0] : route_q;
  end

  // Registered read data; zero whenever this block is not being read
  always_comb begin
    dout_d = '0;
    if (read_en && w_hit) begin
      case (w_off[2:0])
        c_OFF_PEND:  dout_d[nb_src-1:0]   = pend_q;
        c_OFF_ENA:   dout_d[nb_src-1:0]   = ena_q;
        c_OFF_MODE:  dout_d[nb_src-1:0]   = mode_q;
        c_OFF_ROUTE: dout_d[2*nb_src-1:0] = route_q;
        c_OFF_CLAIM: dout_d               = w_claim_val;
        default:     dout_d               = '0;
      endcase
    end
  end

  // Route each active source onto its selected CPU line
  always_comb begin
    irq_d = '0;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < nb_src; k++) begin
        if (w_cand[k] && (route_q[2*k +: 2] == 2'(l))) begin
          irq_d[l] = 1'b1;
        end
      end
    end
  end

  // State and output registers, all frozen while enable is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      pend_q  <= '0;
      ena_q   <= '0;
      mode_q  <= '0;
      route_q <= '0;
      dout_q  <= '0;
      irq_q   <= '0;
    end else if (enable) begin
      prev_q  <= w_src;
      pend_q  <= pend_d;
      ena_q   <= ena_d;
      mode_q  <= mode_d;
      route_q <= route_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
    end
  end

  assign data_out          = dout_q;
  assign interrupt_request = irq_q;

endmodule
`default_nettype wire
